// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite motion engine: FSM states, attribute
// record layout and flag bit positions.
package sprite_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_FL  = 3'd1,
        ST_GET_FL = 3'd2,
        ST_UPD_X  = 3'd3,
        ST_RD_M   = 3'd4,
        ST_UPD_M  = 3'd5,
        ST_WR_FL  = 3'd6,
        ST_NEXT   = 3'd7
    } state_t;

    localparam int FL_EN      = 0;
    localparam int FL_DIR     = 1;
    localparam int FL_ANIM_DN = 2;

    localparam int OFS_X      = 0;
    localparam int OFS_Y      = 1;
    localparam int OFS_FRAME  = 2;
    localparam int OFS_FLAGS  = 3;

    localparam int FRAME_STANDING = 0;

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: counts 0..TICK_COUNT-1 and raises tick for the one
// cycle in which the count sits at its last value.
module tick_gen #(
    parameter int TICK_COUNT = 12500000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_COUNT - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (count_reg == LAST) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign tick = (count_reg == LAST);

endmodule

// File: rtl/sprite_mover.sv
// Periodic multi-sprite mover: once per tick, walks the attribute records,
// advances X with stop/bounce edge handling and ping-pongs the walk frame.
module sprite_mover
    import sprite_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 16,
    parameter int NUM_SPRITES = 4,
    parameter int BASE_ADDR   = 'h1000,
    parameter int STRIDE      = 4,
    parameter int TICK_COUNT  = 12500000,
    parameter int STEP        = 4,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 500,
    parameter int NUM_FRAMES  = 4,
    parameter int BOUNCE      = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pause,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  we,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);

    localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int XW = DATA_WIDTH + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SPRITES - 1);

    state_t                  state_reg, state_next;
    logic [IW-1:0]           idx_reg, idx_next;
    logic [DATA_WIDTH-1:0]   flags_reg, flags_next;
    logic                    stop_reg, stop_next;
    logic                    pending_reg;
    logic                    done_reg;
    logic                    overrun_reg;
    logic                    tick;
    logic                    sweep_start;
    logic                    sweep_end;

    logic [ADDR_WIDTH-1:0]   rec_addr;
    logic [XW-1:0]           x_ext;
    logic [XW-1:0]           x_up;
    logic [DATA_WIDTH-1:0]   x_new;
    logic                    x_edge;
    logic [DATA_WIDTH-1:0]   frame_new;
    logic                    anim_dn_new;

    tick_gen #(
        .TICK_COUNT(TICK_COUNT)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    assign rec_addr = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(idx_reg) * ADDR_WIDTH'(STRIDE);

    // X is widened by one bit so a step past the top of the word range
    // still compares correctly against X_MAX.
    assign x_ext = {1'b0, data_in};
    assign x_up  = x_ext + XW'(STEP);

    always_comb begin
        x_new  = '0;
        x_edge = 1'b0;
        if (!flags_reg[FL_DIR]) begin
            if (x_up >= XW'(X_MAX)) begin
                x_edge = 1'b1;
                x_new  = DATA_WIDTH'(X_MAX);
            end else begin
                x_new  = x_up[DATA_WIDTH-1:0];
            end
        end else begin
            if (x_ext < XW'(X_MIN + STEP)) begin
                x_edge = 1'b1;
                x_new  = DATA_WIDTH'(X_MIN);
            end else begin
                x_new  = data_in - DATA_WIDTH'(STEP);
            end
        end
    end

    // Ping-pong walk cycle 1..NUM_FRAMES-1; out-of-range frames fall back
    // to standing so a corrupted record self-heals.
    always_comb begin
        frame_new   = '0;
        anim_dn_new = flags_reg[FL_ANIM_DN];
        if (stop_reg) begin
            frame_new = DATA_WIDTH'(FRAME_STANDING);
        end else if (data_in == DATA_WIDTH'(FRAME_STANDING)) begin
            frame_new   = DATA_WIDTH'(1);
            anim_dn_new = 1'b0;
        end else if (data_in >= DATA_WIDTH'(NUM_FRAMES)) begin
            frame_new   = DATA_WIDTH'(FRAME_STANDING);
            anim_dn_new = 1'b0;
        end else if (!flags_reg[FL_ANIM_DN]) begin
            frame_new = data_in + 1'b1;
            if (frame_new == DATA_WIDTH'(NUM_FRAMES - 1)) begin
                anim_dn_new = 1'b1;
            end
        end else begin
            frame_new = data_in - 1'b1;
            if (frame_new == DATA_WIDTH'(1)) begin
                anim_dn_new = 1'b0;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        flags_next  = flags_reg;
        stop_next   = stop_reg;
        addr        = '0;
        data_out    = '0;
        we          = 1'b0;
        sweep_start = 1'b0;
        sweep_end   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (pending_reg && !pause) begin
                    sweep_start = 1'b1;
                    idx_next    = '0;
                    state_next  = ST_RD_FL;
                end
            end
            ST_RD_FL: begin
                addr       = rec_addr + ADDR_WIDTH'(OFS_FLAGS);
                state_next = ST_GET_FL;
            end
            ST_GET_FL: begin
                addr       = rec_addr + ADDR_WIDTH'(OFS_X);
                flags_next = data_in;
                state_next = data_in[FL_EN] ? ST_UPD_X : ST_NEXT;
            end
            ST_UPD_X: begin
                addr       = rec_addr + ADDR_WIDTH'(OFS_X);
                we         = 1'b1;
                data_out   = x_new;
                if (x_edge) begin
                    if (BOUNCE != 0) begin
                        flags_next[FL_DIR] = ~flags_reg[FL_DIR];
                    end else begin
                        flags_next[FL_EN] = 1'b0;
                        stop_next         = 1'b1;
                    end
                end
                state_next = ST_RD_M;
            end
            ST_RD_M: begin
                addr       = rec_addr + ADDR_WIDTH'(OFS_FRAME);
                state_next = ST_UPD_M;
            end
            ST_UPD_M: begin
                addr                   = rec_addr + ADDR_WIDTH'(OFS_FRAME);
                we                     = 1'b1;
                data_out               = frame_new;
                flags_next[FL_ANIM_DN] = anim_dn_new;
                state_next             = ST_WR_FL;
            end
            ST_WR_FL: begin
                addr       = rec_addr + ADDR_WIDTH'(OFS_FLAGS);
                we         = 1'b1;
                data_out   = flags_reg;
                stop_next  = 1'b0;
                state_next = ST_NEXT;
            end
            ST_NEXT: begin
                if (idx_reg == LAST_IDX) begin
                    sweep_end  = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    idx_next   = idx_reg + 1'b1;
                    state_next = ST_RD_FL;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // A tick landing on the same cycle the pending one is consumed re-arms
    // pending rather than counting as an overrun.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            idx_reg     <= '0;
            flags_reg   <= '0;
            stop_reg    <= 1'b0;
            pending_reg <= 1'b0;
            done_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            flags_reg   <= flags_next;
            stop_reg    <= stop_next;
            pending_reg <= tick | (pending_reg & ~sweep_start);
            overrun_reg <= tick & pending_reg & ~sweep_start;
            done_reg    <= sweep_end;
        end
    end

    assign busy    = (state_reg != ST_IDLE);
    assign done    = done_reg;
    assign overrun = overrun_reg;

endmodule

// File: tb/tb_sprite_mover.sv
// Bench for sprite_mover: a stop-mode and a bounce-mode instance, each with
// its own 1-cycle-latency RAM, checked against a write scoreboard.
module tb_sprite_mover;

    localparam int TICK = 40;

    logic        clk;
    logic [1:0]  rst_n;
    logic [1:0]  pause;
    logic [15:0] din  [2];
    logic [15:0] addr [2];
    logic [15:0] dout [2];
    logic [1:0]  we, busy, done, overrun;

    logic [15:0] mem [2][16];
    logic        hw_en;
    int          hw_d;
    logic [3:0]  hw_a;
    logic [15:0] hw_v;

    logic [31:0] q0[$];
    logic [31:0] q1[$];

    int mx [2][2];
    int mf [2][2];
    logic [15:0] mfl [2][2];

    int n_tests, n_fail;
    int ovr_cnt [2];
    int done_cnt [2];
    int wr_cnt [2];
    int rise_n [2];
    int done_n [2];
    int seq [8] = '{1, 2, 3, 2, 1, 2, 3, 2};

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        sprite_mover #(
            .DATA_WIDTH(16), .ADDR_WIDTH(16), .NUM_SPRITES(2), .BASE_ADDR('h1000),
            .STRIDE(4), .TICK_COUNT(TICK), .STEP(4), .X_MIN(0), .X_MAX(500),
            .NUM_FRAMES(4), .BOUNCE(gi)
        ) u_dut (
            .clk     (clk),
            .reset   (rst_n[gi]),
            .pause   (pause[gi]),
            .data_in (din[gi]),
            .addr    (addr[gi]),
            .data_out(dout[gi]),
            .we      (we[gi]),
            .busy    (busy[gi]),
            .done    (done[gi]),
            .overrun (overrun[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            din[d] <= mem[d][addr[d][3:0]];
            if (hw_en && hw_d == d) mem[d][hw_a] <= hw_v;
            else if (we[d]) mem[d][addr[d][3:0]] <= dout[d];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] e;
        for (int d = 0; d < 2; d++) begin
            if (overrun[d]) ovr_cnt[d]++;
            if (done[d]) done_cnt[d]++;
            if (we[d]) begin
                wr_cnt[d]++;
                $display("[TB] dut%0d write addr=%h data=%h", d, addr[d], dout[d]);
                if (d == 0 && q0.size() > 0) e = q0.pop_front();
                else if (d == 1 && q1.size() > 0) e = q1.pop_front();
                else e = 32'hDEAD_DEAD;
                check($sformatf("wr%0d", d), {addr[d], dout[d]}, e);
            end
        end
    end

    task automatic push_one(input int d, input logic [15:0] a, input int v);
        if (d == 0) q0.push_back({a, 16'(v)});
        else q1.push_back({a, 16'(v)});
    endtask

    // Expected writes for one sweep of DUT d; instance 1 bounces, 0 stops.
    task automatic push_exp(input int d);
        int x, f, nx, nf;
        logic [15:0] fl, rec;
        logic hit, stp;
        for (int s = 0; s < 2; s++) begin
            x = mx[d][s]; f = mf[d][s]; fl = mfl[d][s];
            rec = 16'h1000 + 16'(4 * s);
            if (fl[0]) begin
                stp = 1'b0;
                if (!fl[1]) begin
                    hit = (x + 4 >= 500);
                    nx = hit ? 500 : x + 4;
                end else begin
                    hit = (x < 4);
                    nx = hit ? 0 : x - 4;
                end
                if (hit) begin
                    if (d == 1) fl[1] = ~fl[1];
                    else begin fl[0] = 1'b0; stp = 1'b1; end
                end
                if (stp) nf = 0;
                else if (f == 0) begin nf = 1; fl[2] = 1'b0; end
                else if (f >= 4) begin nf = 0; fl[2] = 1'b0; end
                else if (!fl[2]) begin nf = f + 1; if (nf == 3) fl[2] = 1'b1; end
                else begin nf = f - 1; if (nf == 1) fl[2] = 1'b0; end
                push_one(d, rec, nx);
                push_one(d, rec + 16'd2, nf);
                push_one(d, rec + 16'd3, int'(fl));
                mx[d][s] = nx; mf[d][s] = nf; mfl[d][s] = fl;
            end
        end
    endtask

    task automatic host_wr(input int d, input logic [3:0] a, input logic [15:0] v);
        hw_en = 1'b1; hw_d = d; hw_a = a; hw_v = v;
        @(negedge clk);
        hw_en = 1'b0;
    endtask

    // Pushes expectations, then waits (bounded) for done on every active DUT.
    task automatic run_sweep(input logic [1:0] act);
        int n;
        logic [1:0] seen;
        n = 0; seen = ~act;
        rise_n = '{-1, -1}; done_n = '{-1, -1};
        for (int d = 0; d < 2; d++) if (act[d]) push_exp(d);
        while (seen != 2'b11 && n < 200) begin
            @(posedge clk); n++;
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (act[d]) begin
                    if (busy[d] && rise_n[d] < 0) rise_n[d] = n;
                    if (done[d] && !seen[d]) begin seen[d] = 1'b1; done_n[d] = n; end
                end
            end
        end
        check("sweep_done", 32'(seen), 32'h3);
        if (act[0]) check("q0_empty", 32'(q0.size()), 0);
        if (act[1]) check("q1_empty", 32'(q1.size()), 0);
    endtask

    task automatic check_idle_outputs(input int d, input string tag);
        check({tag, "_addr"}, 32'(addr[d]), 0);
        check({tag, "_dout"}, 32'(dout[d]), 0);
        check({tag, "_we"}, 32'(we[d]), 0);
        check({tag, "_busy"}, 32'(busy[d]), 0);
        check({tag, "_done"}, 32'(done[d]), 0);
        check({tag, "_ovr"}, 32'(overrun[d]), 0);
    endtask

    initial begin
        int o0, o1, w0, w1, d0, d1, n;
        logic found;
        n_tests = 0; n_fail = 0;
        rst_n = 2'b11; pause = 2'b00; hw_en = 1'b0; hw_d = 0; hw_a = '0; hw_v = '0;
        #2 rst_n = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs(0, "rst0");
        check_idle_outputs(1, "rst1");

        host_wr(0, 0, 16'd10);  host_wr(0, 1, 16'd77); host_wr(0, 2, 16'd0);  host_wr(0, 3, 16'h0081);
        host_wr(0, 4, 16'd20);  host_wr(0, 5, 16'd5);  host_wr(0, 6, 16'd2);  host_wr(0, 7, 16'h0010);
        host_wr(1, 0, 16'd498); host_wr(1, 1, 16'd0);  host_wr(1, 2, 16'd0);  host_wr(1, 3, 16'h0001);
        host_wr(1, 4, 16'd0);   host_wr(1, 5, 16'd0);  host_wr(1, 6, 16'd0);  host_wr(1, 7, 16'h0000);
        mx[0] = '{10, 20};  mf[0] = '{0, 2}; mfl[0] = '{16'h0081, 16'h0010};
        mx[1] = '{498, 0};  mf[1] = '{0, 0}; mfl[1] = '{16'h0001, 16'h0000};

        rst_n = 2'b11;
        for (int k = 0; k < 8; k++) begin
            run_sweep(2'b11);
            $display("[TB] sweep %0d: dut0 x=%0d frame=%0d, dut1 x=%0d flags=%h", k, mem[0][0], mem[0][2], mem[1][0], mem[1][3]);
            check("frame_seq", 32'(mem[0][2]), 32'(seq[k]));
            if (k == 0) begin
                // first tick at TICK, one more cycle for pending to start the sweep
                check("first_busy_rise", 32'(rise_n[0]), TICK + 1);
                check("busy_to_done", 32'(done_n[0] - rise_n[0]), 10);
                check("x_step", 32'(mem[0][0]), 14);
                check("spr1_x", 32'(mem[0][4]), 20);
                check("spr1_y", 32'(mem[0][5]), 5);
                check("spr1_frame", 32'(mem[0][6]), 2);
                check("spr1_flags", 32'(mem[0][7]), 16'h0010);
                check("bounce_x_max", 32'(mem[1][0]), 500);
                check("bounce_dir_set", 32'(mem[1][3]), 16'h0003);
            end else if (k == 1) begin
                check("bounce_x_back", 32'(mem[1][0]), 496);
                host_wr(1, 0, 16'd2);
                mx[1][0] = 2;
            end else if (k == 2) begin
                check("bounce_x_min", 32'(mem[1][0]), 0);
                check("bounce_dir_clr", 32'(mem[1][3] & 16'h0003), 16'h0001);
            end
        end

        host_wr(0, 0, 16'd498);
        mx[0][0] = 498;
        run_sweep(2'b11);
        check("stop_x", 32'(mem[0][0]), 500);
        check("stop_frame", 32'(mem[0][2]), 0);
        check("stop_en", 32'(mem[0][3] & 16'h0001), 0);
        check("stop_other_bits", 32'(mem[0][3] & 16'hFFF8), 16'h0080);
        w0 = wr_cnt[0];
        run_sweep(2'b11);
        check("stopped_no_wr", 32'(wr_cnt[0] - w0), 0);
        check("stopped_x", 32'(mem[0][0]), 500);

        o0 = ovr_cnt[0]; o1 = ovr_cnt[1]; w0 = wr_cnt[0]; w1 = wr_cnt[1];
        pause = 2'b11;
        repeat (80) @(negedge clk);
        check("pause_ovr0", 32'(ovr_cnt[0] - o0), 1);
        check("pause_ovr1", 32'(ovr_cnt[1] - o1), 1);
        check("pause_wr0", 32'(wr_cnt[0] - w0), 0);
        check("pause_wr1", 32'(wr_cnt[1] - w1), 0);
        d0 = done_cnt[0]; d1 = done_cnt[1];
        pause = 2'b00;
        run_sweep(2'b11);
        repeat (15) @(negedge clk);
        check("resume_one_sweep0", 32'(done_cnt[0] - d0), 1);
        check("resume_one_sweep1", 32'(done_cnt[1] - d1), 1);
        pause = 2'b11;

        host_wr(0, 0, 16'd100); host_wr(0, 2, 16'd0); host_wr(0, 3, 16'h0001);
        mx[0][0] = 100; mf[0][0] = 0; mfl[0][0] = 16'h0001;
        q0.push_back({16'h1000, 16'd104});
        pause[0] = 1'b0;
        found = 1'b0;
        n = 0;
        while (!found && n < 100) begin
            @(negedge clk); n++;
            found = busy[0] && !we[0] && addr[0] == 16'h1002;
        end
        check("reach_rd_m", 32'(found), 1);
        @(posedge clk);
        #1 rst_n[0] = 1'b0;
        #1 check_idle_outputs(0, "abort");
        check("abort_q_empty", 32'(q0.size()), 0);
        repeat (3) @(negedge clk);
        check("abort_x_kept", 32'(mem[0][0]), 104);
        check("abort_no_frame_wr", 32'(mem[0][2]), 0);
        check("abort_no_flags_wr", 32'(mem[0][3]), 16'h0001);
        mx[0][0] = 104;
        rst_n[0] = 1'b1;
        run_sweep(2'b01);
        check("post_reset_busy_rise", 32'(rise_n[0]), TICK + 1);
        check("post_reset_x", 32'(mem[0][0]), 108);
        check("post_reset_frame", 32'(mem[0][2]), 1);
        check("final_spr1_flags", 32'(mem[0][7]), 16'h0010);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
